// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser driven by an N_TICK-oversampled baud strobe.
// Optional even-parity checking is enabled by defining RX_PARITY_EN.
module uart_rx #(
    parameter int N_BIT  = 8,
    parameter int N_TICK = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TICK,
    input  logic             RX,
    output logic [N_BIT-1:0] DOUT,
    output logic             RX_DONE,
    output logic             FRAME_ERR,
    output logic             PAR_ERR,
    output logic [2:0]       STATE
);

    localparam int SW = $clog2(N_TICK);
    localparam int NW = $clog2(N_BIT);
    localparam logic [SW-1:0] S_HALF = SW'(N_TICK/2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    state_t           state, state_next;
    logic [SW-1:0]    s, s_next;
    logic [NW-1:0]    n, n_next;
    logic [N_BIT-1:0] b, b_next;
    logic             rx_meta, rx_s, rx_d;
    logic             done_next;
`ifdef RX_PARITY_EN
    logic             p, p_next;
`endif

    // Two-flop synchroniser plus one delay flop; idle-high reset avoids a false start edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples its source from before this edge.
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
`ifdef RX_PARITY_EN
            p     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
`ifdef RX_PARITY_EN
            p     <= p_next;
`endif
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
`ifdef RX_PARITY_EN
        p_next     = p;
`endif
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (TICK) begin
                    if (s == S_HALF) begin
                        state_next = rx_s ? IDLE : DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (TICK) begin
                    if (s == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[N_BIT-1:1]};
                        if (n == N_LAST) begin
`ifdef RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (TICK) begin
                    if (s == S_LAST) begin
                        p_next     = rx_s;
                        state_next = STOP;
                        s_next     = '0;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (TICK) begin
                    // Leave at the stop-bit centre so a following start edge is not missed.
                    if (s == S_LAST) begin
                        state_next = IDLE;
                        s_next     = '0;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done_next = (state == STOP) && TICK && (s == S_LAST);
        STATE     = state;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DOUT      <= '0;
            RX_DONE   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            RX_DONE <= done_next;
            if (done_next) begin
                DOUT      <= b;
                FRAME_ERR <= ~rx_s;
            end
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PAR_ERR <= 1'b0;
        end else if (done_next) begin
            PAR_ERR <= (^b) ^ p;
        end
    end
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, expected results queued
// when a frame is driven and compared when RX_DONE fires.
module tb_uart_rx;

    localparam int N_BIT    = 8;
    localparam int N_TICK   = 16;
    localparam int TICK_DIV = 3;
    localparam int BIT_CLKS = N_TICK * TICK_DIV;

    logic             CLK;
    logic             RESET_N;
    logic             TICK;
    logic             RX;
    logic [N_BIT-1:0] DOUT;
    logic             RX_DONE;
    logic             FRAME_ERR;
    logic             PAR_ERR;
    logic [2:0]       STATE;

    typedef struct packed {
        logic [N_BIT-1:0] d;
        logic             fe;
        logic             pe;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    uart_rx #(.N_BIT(N_BIT), .N_TICK(N_TICK)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .TICK     (TICK),
        .RX       (RX),
        .DOUT     (DOUT),
        .RX_DONE  (RX_DONE),
        .FRAME_ERR(FRAME_ERR),
        .PAR_ERR  (PAR_ERR),
        .STATE    (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        TICK = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge CLK);
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (RX_DONE) begin
                exp_t e;
                done_cnt++;
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("dout", 32'(DOUT), 32'(e.d));
                    check("frame_err", 32'(FRAME_ERR), 32'(e.fe));
                    check("par_err", 32'(PAR_ERR), 32'(e.pe));
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        RX = v;
        repeat (BIT_CLKS) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [N_BIT-1:0] d, input logic stop, input logic par);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
`ifdef RX_PARITY_EN
        e.pe = (^d) ^ par;
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < N_BIT; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge CLK);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(DOUT), 32'd0);
        check({tag, "_done"}, 32'(RX_DONE), 32'd0);
        check({tag, "_ferr"}, 32'(FRAME_ERR), 32'd0);
        check({tag, "_perr"}, 32'(PAR_ERR), 32'd0);
        check({tag, "_state"}, 32'(STATE), 32'd0);
    endtask

    initial begin
        int base;
        RX      = 1'b1;
        RESET_N = 1'b0;
        repeat (4) @(negedge CLK);
        check_reset_outputs("por");
        RESET_N = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge CLK);

        // Reset in the middle of a frame aborts it.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("midframe_state", 32'(STATE), 32'd2);
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        RX = 1'b1;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (10 * BIT_CLKS) @(negedge CLK);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_dout", 32'(DOUT), 32'd0);

        // Clean frame.
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_drain("a5_drain");
        drive_bit(1'b1);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_idle", 32'(STATE), 32'd0);

        // Start-bit glitch of four ticks.
        RX = 1'b0;
        repeat (4 * TICK_DIV) @(negedge CLK);
        check("glitch_start", 32'(STATE), 32'd1);
        RX = 1'b1;
        repeat (10 * TICK_DIV) @(negedge CLK);
        check("glitch_idle", 32'(STATE), 32'd0);
        check("glitch_no_done", 32'(done_cnt), 32'd1);
        check("glitch_dout", 32'(DOUT), 32'hA5);
        drive_bit(1'b1);

        // Stop bit low, then the line stays low (break) without retriggering.
        base = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge CLK);
        wait_drain("3c_drain");
        check("break_idle", 32'(STATE), 32'd0);
        check("break_one_done", 32'(done_cnt - base), 32'd1);
        check("break_ferr_held", 32'(FRAME_ERR), 32'd1);
        drive_bit(1'b1);

        // Back-to-back frames with no idle gap.
        base = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain("b2b_drain");
        drive_bit(1'b1);
        check("b2b_three_done", 32'(done_cnt - base), 32'd3);
        check("b2b_ferr", 32'(FRAME_ERR), 32'd0);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("par_bad_drain");
        drive_bit(1'b1);
        check("par_bad_held", 32'(PAR_ERR), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain("par_good_drain");
        drive_bit(1'b1);
        check("par_good_held", 32'(PAR_ERR), 32'd0);
`endif

        repeat (BIT_CLKS) @(negedge CLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
